// File: rtl/lock_controller.sv
// Initiator side of the locked-register protection interface: sticky lock,
// key-authenticated debug window with timeout, and failed-attempt lockout.
module lock_controller #(
  parameter logic [15:0] KEY          = 16'hA5C3,
  parameter int          MAX_ATTEMPTS = 3,
  parameter int          CHAL_CYCLES  = 16,
  parameter int          DEBUG_CYCLES = 8,
  localparam int         FW           = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lock_req,
  input  logic          unlock_req,
  input  logic          key_valid,
  input  logic [15:0]   key_in,
  input  logic          debug_exit,
  output logic          lock_status,
  output logic          debug_unlocked,
  output logic [FW-1:0] fail_count,
  output logic          lockout,
  output logic          chal_active
);

  localparam int TMAX = (CHAL_CYCLES > DEBUG_CYCLES) ? CHAL_CYCLES : DEBUG_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [FW-1:0] MAX_F = FW'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_UNLOCKED, S_LOCKED, S_CHALLENGE, S_DEBUG, S_LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic            lock_q, lock_d;
  logic            dbg_q, dbg_d;
  logic            lko_q, lko_d;
  logic            chal_q, chal_d;
  logic            fail_hit;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    fail_d   = fail_q;
    fail_hit = 1'b0;
    case (state_q)
      S_UNLOCKED: if (lock_req) state_d = S_LOCKED;
      S_LOCKED: begin
        if (unlock_req) begin
          state_d = S_CHALLENGE;
          tmr_d   = TW'(CHAL_CYCLES);
        end
      end
      S_CHALLENGE: begin
        tmr_d = tmr_q - TW'(1);
        // A presented key always wins over a simultaneous timeout.
        if (key_valid) begin
          if (key_in == KEY) begin
            state_d = S_DEBUG;
            fail_d  = '0;
            tmr_d   = TW'(DEBUG_CYCLES);
          end else begin
            fail_hit = 1'b1;
          end
        end else if (tmr_q <= TW'(1)) begin
          fail_hit = 1'b1;
        end
        if (fail_hit) begin
          fail_d  = (fail_q == MAX_F) ? fail_q : fail_q + FW'(1);
          state_d = (fail_d == MAX_F) ? S_LOCKOUT : S_LOCKED;
        end
      end
      S_DEBUG: begin
        tmr_d = tmr_q - TW'(1);
        // Timer holds N on the first cycle, so leaving at 1 gives exactly N cycles.
        if (debug_exit || tmr_q <= TW'(1)) state_d = S_LOCKED;
      end
      S_LOCKOUT: state_d = S_LOCKOUT;
      default:   state_d = S_UNLOCKED;
    endcase

    lock_d = (state_d != S_UNLOCKED);
    dbg_d  = (state_d == S_DEBUG);
    lko_d  = (state_d == S_LOCKOUT);
    chal_d = (state_d == S_CHALLENGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_UNLOCKED;
      tmr_q   <= '0;
      fail_q  <= '0;
      lock_q  <= 1'b0;
      dbg_q   <= 1'b0;
      lko_q   <= 1'b0;
      chal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      dbg_q   <= dbg_d;
      lko_q   <= lko_d;
      chal_q  <= chal_d;
    end
  end

  assign lock_status    = lock_q;
  assign debug_unlocked = dbg_q;
  assign fail_count     = fail_q;
  assign lockout        = lko_q;
  assign chal_active    = chal_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller: lock, debug window, failures, lockout,
// challenge timeout and asynchronous reset.
module tb_lock_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        lock_req, unlock_req, key_valid, debug_exit;
  logic [15:0] key_in;
  logic        lock_status, debug_unlocked, lockout, chal_active;
  logic [1:0]  fail_count;

  int checks = 0;
  int errors = 0;

  lock_controller dut (
    .clk(clk), .reset(reset), .lock_req(lock_req), .unlock_req(unlock_req),
    .key_valid(key_valid), .key_in(key_in), .debug_exit(debug_exit),
    .lock_status(lock_status), .debug_unlocked(debug_unlocked),
    .fail_count(fail_count), .lockout(lockout), .chal_active(chal_active)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; lock_req = 0; unlock_req = 0; key_valid = 0;
    key_in = 16'h0; debug_exit = 0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic pulse_lock();
    lock_req = 1; step(); lock_req = 0;
  endtask

  task automatic pulse_unlock();
    unlock_req = 1; step(); unlock_req = 0;
  endtask

  task automatic send_key(input logic [15:0] k);
    key_valid = 1; key_in = k; step(); key_valid = 0; key_in = 16'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; lock_req = 0; unlock_req = 0; key_valid = 0;
    key_in = 16'h0; debug_exit = 0;
    #2;
    checks++; if (lock_status !== 1'b0) begin errors++; $display("FAIL reset_lock got %b exp 0", lock_status); end
    checks++; if (debug_unlocked !== 1'b0) begin errors++; $display("FAIL reset_dbg got %b exp 0", debug_unlocked); end
    checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL reset_fail got %0d exp 0", fail_count); end
    checks++; if (lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout got %b exp 0", lockout); end
    checks++; if (chal_active !== 1'b0) begin errors++; $display("FAIL reset_chal got %b exp 0", chal_active); end
    step(); reset = 1'b0; step();
    // Challenge inputs in UNLOCKED are ignored.
    unlock_req = 1; key_valid = 1; key_in = 16'hA5C3; step();
    unlock_req = 0; key_valid = 0; key_in = 16'h0;
    checks++; if (lock_status !== 1'b0 || chal_active !== 1'b0 || debug_unlocked !== 1'b0) begin
      errors++; $display("FAIL unlocked_ignore got lock=%b chal=%b dbg=%b exp 0 0 0", lock_status, chal_active, debug_unlocked); end
  endtask

  task automatic test_lock_and_debug();
    pulse_lock();
    checks++; if (lock_status !== 1'b1) begin errors++; $display("FAIL lock_set got %b exp 1", lock_status); end
    pulse_unlock();
    checks++; if (chal_active !== 1'b1) begin errors++; $display("FAIL chal_enter got %b exp 1", chal_active); end
    send_key(16'hA5C3);
    for (int i = 0; i < 8; i++) begin
      checks++; if (debug_unlocked !== 1'b1 || lock_status !== 1'b1) begin
        errors++; $display("FAIL dbg_window cyc %0d got dbg=%b lock=%b exp 1 1", i + 1, debug_unlocked, lock_status); end
      step();
    end
    checks++; if (debug_unlocked !== 1'b0) begin errors++; $display("FAIL dbg_expire got %b exp 0", debug_unlocked); end
    checks++; if (lock_status !== 1'b1) begin errors++; $display("FAIL dbg_expire_lock got %b exp 1", lock_status); end
    checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL dbg_expire_fail got %0d exp 0", fail_count); end
    // lock_req in LOCKED is ignored and the lock stays set.
    pulse_lock(); step();
    checks++; if (lock_status !== 1'b1 || chal_active !== 1'b0) begin
      errors++; $display("FAIL locked_sticky got lock=%b chal=%b exp 1 0", lock_status, chal_active); end
  endtask

  task automatic test_debug_exit();
    pulse_unlock();
    send_key(16'hA5C3);
    step(); step();
    checks++; if (debug_unlocked !== 1'b1) begin errors++; $display("FAIL exit_pre got %b exp 1", debug_unlocked); end
    debug_exit = 1; step(); debug_exit = 0;
    checks++; if (debug_unlocked !== 1'b0 || lock_status !== 1'b1 || chal_active !== 1'b0 || lockout !== 1'b0) begin
      errors++; $display("FAIL exit_locked got dbg=%b lock=%b chal=%b lko=%b exp 0 1 0 0",
                        debug_unlocked, lock_status, chal_active, lockout); end
    // Back in LOCKED: a new challenge can open.
    pulse_unlock();
    checks++; if (chal_active !== 1'b1) begin errors++; $display("FAIL exit_relock got %b exp 1", chal_active); end
    send_key(16'h0000);
    checks++; if (fail_count !== 2'd1 || chal_active !== 1'b0) begin
      errors++; $display("FAIL exit_badkey got fail=%0d chal=%b exp 1 0", fail_count, chal_active); end
  endtask

  task automatic test_lockout();
    do_reset();
    pulse_lock();
    for (int n = 1; n <= 3; n++) begin
      pulse_unlock();
      send_key(16'h1111);
      checks++; if (fail_count !== 2'(n)) begin errors++; $display("FAIL lko_count n=%0d got %0d exp %0d", n, fail_count, n); end
      checks++; if (lockout !== (n == 3)) begin errors++; $display("FAIL lko_flag n=%0d got %b exp %b", n, lockout, (n == 3)); end
    end
    pulse_unlock();
    send_key(16'hA5C3);
    for (int i = 0; i < 4; i++) begin
      checks++; if (debug_unlocked !== 1'b0 || lockout !== 1'b1 || fail_count !== 2'd3 || lock_status !== 1'b1) begin
        errors++; $display("FAIL lko_hold got dbg=%b lko=%b fail=%0d lock=%b exp 0 1 3 1",
                          debug_unlocked, lockout, fail_count, lock_status); end
      step();
    end
  endtask

  task automatic test_clear_and_timeout();
    do_reset();
    pulse_lock();
    pulse_unlock(); send_key(16'h1111);
    pulse_unlock(); send_key(16'h2222);
    checks++; if (fail_count !== 2'd2) begin errors++; $display("FAIL clr_pre got %0d exp 2", fail_count); end
    pulse_unlock(); send_key(16'hA5C3);
    checks++; if (fail_count !== 2'd0 || debug_unlocked !== 1'b1) begin
      errors++; $display("FAIL clr_good got fail=%0d dbg=%b exp 0 1", fail_count, debug_unlocked); end
    debug_exit = 1; step(); debug_exit = 0;
    pulse_unlock();
    // unlock_req held inside CHALLENGE must not restart the timer.
    unlock_req = 1;
    for (int i = 1; i < 16; i++) begin
      checks++; if (chal_active !== 1'b1) begin errors++; $display("FAIL tmo_wait cyc %0d got %b exp 1", i, chal_active); end
      step();
    end
    unlock_req = 0;
    checks++; if (chal_active !== 1'b1) begin errors++; $display("FAIL tmo_last got %b exp 1", chal_active); end
    step();
    checks++; if (chal_active !== 1'b0 || fail_count !== 2'd1 || lock_status !== 1'b1 || lockout !== 1'b0) begin
      errors++; $display("FAIL tmo_fire got chal=%b fail=%0d lock=%b lko=%b exp 0 1 1 0",
                        chal_active, fail_count, lock_status, lockout); end
  endtask

  task automatic test_key_at_timeout();
    pulse_unlock();
    for (int i = 1; i < 16; i++) step();
    checks++; if (chal_active !== 1'b1) begin errors++; $display("FAIL kt_pre got %b exp 1", chal_active); end
    send_key(16'hA5C3);
    checks++; if (debug_unlocked !== 1'b1 || fail_count !== 2'd0) begin
      errors++; $display("FAIL kt_debug got dbg=%b fail=%0d exp 1 0", debug_unlocked, fail_count); end
  endtask

  task automatic test_async_reset();
    step();
    checks++; if (debug_unlocked !== 1'b1) begin errors++; $display("FAIL ar_pre got %b exp 1", debug_unlocked); end
    #2 reset = 1'b1;
    #1;
    checks++; if (debug_unlocked !== 1'b0 || lock_status !== 1'b0 || lockout !== 1'b0 || fail_count !== 2'd0) begin
      errors++; $display("FAIL ar_now got dbg=%b lock=%b lko=%b fail=%0d exp 0 0 0 0",
                        debug_unlocked, lock_status, lockout, fail_count); end
    step(); reset = 1'b0; step();
    checks++; if (lock_status !== 1'b0 || chal_active !== 1'b0) begin
      errors++; $display("FAIL ar_after got lock=%b chal=%b exp 0 0", lock_status, chal_active); end
  endtask

  initial begin
    test_reset();
    test_lock_and_debug();
    test_debug_exit();
    test_lockout();
    test_clear_and_timeout();
    test_key_at_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
